mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// - Memory-access stage: consumes exe_to_mem_t from exe, produces mem_to_wb_t for writeback.
// - Drives loads/stores to data memory (valid/ready request, valid-only response); ALU ops pass through.
// - Byte/half/word access: byte enables, store-data replication, load extraction, sign/zero extension.
// - Flags misaligned accesses; single in-flight transaction; one-entry output register.
// PARAMETERS
// - ADDR_WIDTH  32  data-memory byte-address width (low 2 bits are byte offset)
// - DATA_WIDTH  32  data width; only 32 is supported
// PORTS
// - clk_i            in   1    clock
// - rst_i            in   1    asynchronous, active-high reset
// - valid_i          in   1    exe_to_mem_i valid
// - ready_o          out  1    stage can accept exe_to_mem_i
// - exe_to_mem_i     in   exe_to_mem_t   pc, alu_result, store_data, mem_op, mem_size, mem_unsigned, addr_rd, write_rd
// - valid_o          out  1    mem_to_wb_o valid
// - ready_i          in   1    writeback accepts mem_to_wb_o
// - mem_to_wb_o      out  mem_to_wb_t    pc, rd_data, addr_rd, write_rd, misaligned
// - dmem_req_valid_o out  1    memory request valid
// - dmem_req_ready_i in   1    memory accepts request
// - dmem_addr_o      out  ADDR_WIDTH  word-aligned address (alu_result with [1:0]=0)
// - dmem_we_o        out  1    1 = store, 0 = load
// - dmem_be_o        out  4    byte enables
// - dmem_wdata_o     out  32   replicated store data
// - dmem_rsp_valid_i in   1    load response valid (one-cycle pulse)
// - dmem_rdata_i     in   32   load response data
// BEHAVIOUR
// - Reset: FSM=IDLE; valid_o, dmem_req_valid_o, dmem_we_o = 0; dmem_be_o = 0; mem_to_wb_o = 0.
// - FSM states: IDLE, REQ, RSP. ready_o = (state==IDLE) && (!valid_o || ready_i).
// - IDLE, handshake with mem_op=NONE: output reg loads rd_data=alu_result next edge; latency 1.
// - IDLE, handshake with misaligned access (H: addr[0]!=0; W: addr[1:0]!=0): no request is issued;
//   output loads misaligned=1, write_rd=0; latency 1.
// - IDLE, handshake with aligned LOAD/STORE: command is latched; -> REQ; dmem_req_valid_o=1 next cycle.
// - REQ: addr/we/be/wdata are held stable until dmem_req_ready_i.
//   - Accepted store: output loads (write_rd=0); -> IDLE.
//   - Accepted load: -> RSP.
// - RSP: dmem_rsp_valid_i loads the output with extracted data; -> IDLE.
//   - Responses are ignored in IDLE/REQ; memory responds >=1 cycle after acceptance.
// - Byte enables / wdata (off = addr[1:0]):
//   - B: be = 1<<off, wdata = {4{sd[7:0]}}
//   - H: be = 3<<off, wdata = {2{sd[15:0]}}
//   - W: be = 4'hF, wdata = sd
// - Load data: shifted = rdata >> (8*off).
//   - B/H are sign-extended from bit 7/15; zero-extended when mem_unsigned=1.
// - Output reg holds while valid_o && !ready_i; it clears when drained with no new load.
//   - The ready_o rule guarantees the output is free when a load response arrives, so no response is dropped.
// - Reset mid-transaction: abort to IDLE in the same cycle (async); the in-flight request is dropped;
//   a late response is ignored.
// STRUCTURE
// - tartaruga_pkg holds: mem_op_e {MEM_NONE, MEM_LOAD, MEM_STORE}, mem_size_e {SZ_B, SZ_H, SZ_W},
//   mem_state_e, the exe_to_mem_t fields above, and mem_to_wb_t.
// - Sub-module mem_align (combinational): be/wdata generation, misalign detect, load extract/extend.
// TESTING
// - ALU op, alu_result=0x1234, ready_i=1 -> valid_o next cycle, rd_data=0x1234.
// - SB addr=0x103, sd=0xAB -> be=4'b1000, wdata=0xABABABAB, addr=0x100; valid_o with write_rd=0.
// - LB addr=0x101, rdata=0x0000_8000 -> rd_data=0xFFFFFF80; same access as LBU -> 0x00000080.
// - LW addr=0x102 -> no dmem_req_valid_o; valid_o=1, misaligned=1, write_rd=0.
// - dmem_req_ready_i low 3 cycles, then ready_i low 2 cycles after response
//   -> request fields stable; output held; ready_o=0 throughout.
// - rst_i pulsed while in RSP, then rsp_valid arrives -> state IDLE, valid_o=0, response ignored.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga memory stage: pipeline payloads, memory op
// encodings, FSM states and the alignment rule.
package tartaruga_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} mem_op_e;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} mem_size_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_RSP = 2'd2} mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    mem_op_e         mem_op;
    mem_size_e       mem_size;
    logic            mem_unsigned;
    logic [4:0]      addr_rd;
    logic            write_rd;
  } exe_to_mem_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd_data;
    logic [4:0]      addr_rd;
    logic            write_rd;
    logic            misaligned;
  } mem_to_wb_t;

  // Halfwords need an even address, words a multiple of four; bytes never fault.
  function automatic logic is_misaligned(mem_size_e sz, logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus bundle: a valid/ready request channel and a valid-only response channel.
interface mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;

  modport master (output req_valid, addr, we, be, wdata, input req_ready, rsp_valid, rdata);
  modport slave  (input req_valid, addr, we, be, wdata, output req_ready, rsp_valid, rdata);
endinterface

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic: misalignment check, byte enables, store-data
// replication and load-data extraction with sign/zero extension.
module mem_stage_align
  import tartaruga_pkg::*;
(
  input  logic [1:0]  off_i,
  input  mem_size_e   size_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic        misaligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);
  logic [31:0] shifted;

  always_comb begin
    misaligned_o = is_misaligned(size_i, off_i);
    shifted      = rdata_i >> {off_i, 3'b000};
    be_o         = 4'hF;
    wdata_o      = store_data_i;
    load_data_o  = shifted;
    case (size_i)
      SZ_B: begin
        be_o        = 4'b0001 << off_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = unsigned_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        be_o        = 4'b0011 << off_i;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = unsigned_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one load/store at a time to data memory and
// registers the writeback payload in a single output slot.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; once valid is raised the payload is held until that edge. The memory
// response has no ready and is a one-cycle pulse, only honoured in ST_RSP.
module mem_stage
  import tartaruga_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  exe_to_mem_t           exe_to_mem_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output mem_to_wb_t            mem_to_wb_o,
  output logic                  dmem_req_valid_o,
  input  logic                  dmem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic                  dmem_we_o,
  output logic [3:0]            dmem_be_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output mem_state_e            state_o
);
  mem_state_e  state_q, state_d;
  exe_to_mem_t cmd_q, cmd_d;
  mem_to_wb_t  out_q, out_d;
  logic        out_valid_q, out_valid_d;

  exe_to_mem_t src;
  logic        accept, req_active, mis;
  logic [3:0]  be;
  logic [31:0] wdata, load_data;

  // In IDLE the incoming command is inspected; afterwards the latched one drives the lanes.
  assign src        = (state_q == ST_IDLE) ? exe_to_mem_i : cmd_q;
  assign ready_o    = (state_q == ST_IDLE) && (!out_valid_q || ready_i);
  assign accept     = valid_i && ready_o;
  assign req_active = (state_q == ST_REQ);

  mem_stage_align u_align (
    .off_i        (src.alu_result[1:0]),
    .size_i       (src.mem_size),
    .unsigned_i   (src.mem_unsigned),
    .store_data_i (src.store_data),
    .rdata_i      (dmem_rdata_i),
    .misaligned_o (mis),
    .be_o         (be),
    .wdata_o      (wdata),
    .load_data_o  (load_data)
  );

  assign dmem_req_valid_o = req_active;
  assign dmem_addr_o      = req_active ? {cmd_q.alu_result[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign dmem_we_o        = req_active && (cmd_q.mem_op == MEM_STORE);
  assign dmem_be_o        = req_active ? be : 4'h0;
  assign dmem_wdata_o     = req_active ? wdata : '0;
  assign valid_o          = out_valid_q;
  assign mem_to_wb_o      = out_q;
  assign state_o          = state_q;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && ready_i) begin
      out_valid_d = 1'b0;
      out_d       = '0;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          out_d.pc         = exe_to_mem_i.pc;
          out_d.rd_data    = exe_to_mem_i.alu_result;
          out_d.addr_rd    = exe_to_mem_i.addr_rd;
          out_d.write_rd   = exe_to_mem_i.write_rd;
          out_d.misaligned = 1'b0;
          if (exe_to_mem_i.mem_op == MEM_LOAD || exe_to_mem_i.mem_op == MEM_STORE) begin
            if (mis) begin
              out_valid_d      = 1'b1;
              out_d.write_rd   = 1'b0;
              out_d.misaligned = 1'b1;
            end else begin
              out_d   = '0;
              cmd_d   = exe_to_mem_i;
              state_d = ST_REQ;
            end
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (dmem_req_ready_i) begin
          if (cmd_q.mem_op == MEM_STORE) begin
            out_valid_d      = 1'b1;
            out_d.pc         = cmd_q.pc;
            out_d.rd_data    = cmd_q.alu_result;
            out_d.addr_rd    = cmd_q.addr_rd;
            out_d.write_rd   = 1'b0;
            out_d.misaligned = 1'b0;
            state_d          = ST_IDLE;
          end else begin
            state_d = ST_RSP;
          end
        end
      end
      ST_RSP: begin
        if (dmem_rsp_valid_i) begin
          out_valid_d      = 1'b1;
          out_d.pc         = cmd_q.pc;
          out_d.rd_data    = load_data;
          out_d.addr_rd    = cmd_q.addr_rd;
          out_d.write_rd   = cmd_q.write_rd;
          out_d.misaligned = 1'b0;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: randomized commands against a byte-level memory model,
// with request and writeback scoreboards plus directed corner cases.
module tb_mem_stage;
  import tartaruga_pkg::*;

  localparam int WB_W = $bits(mem_to_wb_t);

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        valid_i = 1'b0;
  logic        ready_o;
  exe_to_mem_t exe_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  mem_to_wb_t  wb_o;
  mem_state_e  state_o;

  mem_stage_if bus ();

  mem_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .exe_to_mem_i     (exe_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .mem_to_wb_o      (wb_o),
    .dmem_req_valid_o (bus.req_valid),
    .dmem_req_ready_i (bus.req_ready),
    .dmem_addr_o      (bus.addr),
    .dmem_we_o        (bus.we),
    .dmem_be_o        (bus.be),
    .dmem_wdata_o     (bus.wdata),
    .dmem_rsp_valid_i (bus.rsp_valid),
    .dmem_rdata_i     (bus.rdata),
    .state_o          (state_o)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [WB_W-1:0] exp_q[$];
  bit              care_q[$];
  req_t            req_q[$];
  logic [7:0]      model_mem[256];
  logic [31:0]     dev_mem[64];
  int              rr_mode = 1;   // 0 random, 1 high, 2 low
  int              ri_mode = 1;
  int              rsp_delay = 0; // 0 = random 1..3
  int              req_seen = 0;
  mem_to_wb_t      last_wb = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    dev_mem[a[7:2]] = v;
    for (int i = 0; i < 4; i++) model_mem[{a[7:2], 2'b00} + 8'(i)] = v[8*i +: 8];
  endtask

  // Reference model: byte-addressed memory, accesses computed from size and offset.
  function automatic void predict(input exe_to_mem_t c);
    int          n, off;
    logic [31:0] a, v;
    mem_to_wb_t  e;
    req_t        r;
    e = '0;
    e.pc = c.pc;
    e.addr_rd = c.addr_rd;
    a = c.alu_result;
    if (c.mem_op != MEM_LOAD && c.mem_op != MEM_STORE) begin
      e.rd_data = a;
      e.write_rd = c.write_rd;
      exp_q.push_back(e); care_q.push_back(1'b1);
      return;
    end
    n = (c.mem_size == SZ_B) ? 1 : (c.mem_size == SZ_H) ? 2 : 4;
    off = int'(a % 4);
    if (a % n != 0) begin
      e.misaligned = 1'b1;
      exp_q.push_back(e); care_q.push_back(1'b0);
      return;
    end
    r.addr = a - 32'(off);
    r.we = (c.mem_op == MEM_STORE);
    r.be = '0;
    r.wdata = '0;
    for (int j = 0; j < 4; j++) begin
      if (j >= off && j < off + n) r.be[j] = 1'b1;
      if (r.we) r.wdata[8*j +: 8] = c.store_data[8*(j % n) +: 8];
    end
    req_q.push_back(r);
    if (r.we) begin
      for (int i = 0; i < n; i++) model_mem[a[7:0] + 8'(i)] = c.store_data[8*i +: 8];
      exp_q.push_back(e); care_q.push_back(1'b0);
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(model_mem[a[7:0] + 8'(i)]) << (8*i));
      if (!c.mem_unsigned && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e.rd_data = v;
      e.write_rd = c.write_rd;
      exp_q.push_back(e); care_q.push_back(1'b1);
    end
  endfunction

  // ---------------- ready drivers ----------------
  initial begin
    bus.req_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.req_ready = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : (rr_mode == 1);
      ready_i       = (ri_mode == 0) ? ($urandom_range(0, 3) != 0) : (ri_mode == 1);
    end
  end

  // ---------------- memory responder + request monitor ----------------
  initial begin
    int          pend = 0;
    logic [31:0] pend_data = '0;
    req_t        act, ex;
    bus.rsp_valid = 1'b0;
    bus.rdata = '0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rdata = pend_data;
        end
      end
      #1;
      if (!rst && bus.req_valid && bus.req_ready) begin
        req_seen++;
        act = {bus.addr, bus.we, bus.be, bus.we ? bus.wdata : 32'h0};
        if (req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got %0h expected none", act);
        end else begin
          ex = req_q.pop_front();
          check("dmem_req", 128'(act), 128'(ex));
        end
        if (bus.we) begin
          for (int j = 0; j < 4; j++)
            if (bus.be[j]) dev_mem[bus.addr[7:2]][8*j +: 8] = bus.wdata[8*j +: 8];
        end else begin
          pend = (rsp_delay == 0) ? $urandom_range(1, 3) : rsp_delay;
          pend_data = dev_mem[bus.addr[7:2]];
        end
      end
    end
  end

  // ---------------- writeback monitor ----------------
  initial begin
    mem_to_wb_t e, a;
    bit c;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && valid_o && ready_i) begin
        last_wb = wb_o;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_wb: got %0h expected none", wb_o);
        end else begin
          e = exp_q.pop_front();
          c = care_q.pop_front();
          a = wb_o;
          if (!c) begin a.rd_data = '0; e.rd_data = '0; end
          check("wb_out", 128'(a), 128'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input exe_to_mem_t c);
    int t = 0;
    @(negedge clk);
    valid_i = 1'b1;
    exe_i = c;
    forever begin
      #1;
      if (ready_o) break;
      if (++t > 300) begin
        total++; bad++;
        $display("FAIL issue_timeout: got ready_o=0 expected 1");
        valid_i = 1'b0;
        return;
      end
      @(negedge clk);
    end
    predict(c);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  function automatic exe_to_mem_t mk(input mem_op_e op, input mem_size_e sz, input logic uns,
                                     input logic [31:0] a, input logic [31:0] sd);
    exe_to_mem_t c;
    c.pc = $urandom;
    c.alu_result = a;
    c.store_data = sd;
    c.mem_op = op;
    c.mem_size = sz;
    c.mem_unsigned = uns;
    c.addr_rd = 5'($urandom_range(1, 31));
    c.write_rd = 1'b1;
    return c;
  endfunction

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0 || state_o != ST_IDLE) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(name, 128'(exp_q.size() + req_q.size()), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    exe_to_mem_t c;
    int t;
    for (int w = 0; w < 64; w++) set_word({24'h1, 6'(w), 2'b00}, $urandom);

    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 128'(state_o), 128'(ST_IDLE));
    check("rst_valid_o", 128'(valid_o), 128'(0));
    check("rst_req", 128'({bus.req_valid, bus.we, bus.be}), 128'(0));
    check("rst_wb", 128'(wb_o), 128'(0));
    rst = 1'b0;

    // ALU pass-through, one-cycle latency
    issue(mk(MEM_NONE, SZ_W, 1'b0, 32'h1234, 32'h0));
    check("alu_latency", 128'(valid_o), 128'(1));
    check("alu_rd_data", 128'(wb_o.rd_data), 128'(32'h1234));

    issue(mk(MEM_STORE, SZ_B, 1'b0, 32'h103, 32'hAB));
    drain("sb_drain");

    set_word(32'h100, 32'h0000_8000);
    issue(mk(MEM_LOAD, SZ_B, 1'b0, 32'h101, 32'h0));
    drain("lb_drain");
    check("lb_value", 128'(last_wb.rd_data), 128'(32'hFFFF_FF80));
    issue(mk(MEM_LOAD, SZ_B, 1'b1, 32'h101, 32'h0));
    drain("lbu_drain");
    check("lbu_value", 128'(last_wb.rd_data), 128'(32'h0000_0080));

    // misaligned word: no request at all
    t = req_seen;
    issue(mk(MEM_LOAD, SZ_W, 1'b0, 32'h102, 32'h0));
    drain("lw_mis_drain");
    check("lw_mis_noreq", 128'(req_seen), 128'(t));
    check("lw_mis_flags", 128'({last_wb.misaligned, last_wb.write_rd}), 128'(2'b10));

    // memory stall for three cycles, then writeback stall for two
    rr_mode = 2;
    rsp_delay = 1;
    issue(mk(MEM_LOAD, SZ_W, 1'b0, 32'h104, 32'h0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("stall_req_hold", 128'({bus.req_valid, bus.addr, bus.we, bus.be, ready_o}),
            128'({1'b1, 32'h104, 1'b0, 4'hF, 1'b0}));
    end
    ri_mode = 2;
    rr_mode = 1;
    t = 0;
    while (!valid_o && t < 20) begin @(negedge clk); #1; t++; end
    check("stall_rsp_seen", 128'(valid_o), 128'(1));
    for (int i = 0; i < 2; i++) begin
      check("stall_out_hold", 128'({wb_o, valid_o, ready_o}), 128'({exp_q[0], 1'b1, 1'b0}));
      @(negedge clk);
      #1;
    end
    ri_mode = 1;
    drain("stall_drain");

    // reset while waiting for a response; the late response must be ignored
    rsp_delay = 4;
    issue(mk(MEM_LOAD, SZ_W, 1'b0, 32'h108, 32'h0));
    t = 0;
    while (state_o != ST_RSP && t < 20) begin @(negedge clk); #1; t++; end
    check("rst_mid_in_rsp", 128'(state_o), 128'(ST_RSP));
    #2 rst = 1'b1;
    #1 check("rst_mid_async", 128'(state_o), 128'(ST_IDLE));
    exp_q.delete();
    care_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("late_rsp_ignored", 128'({state_o, valid_o}), 128'({ST_IDLE, 1'b0}));
    end
    rsp_delay = 0;

    // randomized traffic with random back-pressure on both sides
    rr_mode = 0;
    ri_mode = 0;
    for (int k = 0; k < 300; k++) begin
      c = mk(mem_op_e'($urandom_range(0, 2)), mem_size_e'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), {24'h1, 8'($urandom_range(0, 255))}, $urandom);
      c.write_rd = 1'($urandom_range(0, 1));
      issue(c);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    ri_mode = 1;
    rr_mode = 1;
    drain("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
